// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address LIFO with occupancy and sticky error flags
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] stack_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] stack_out,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [PTR_W:0] max_cnt = (PTR_W+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp, top, wa;
  logic replace, do_push, do_pop, ov_set, un_set;
  always_comb begin
    top     = wp - PTR_W'(1);
    replace = push && pop && !empty;
    do_push = push && !replace;
    do_pop  = pop && !push && !empty;
    ov_set  = do_push && full;
    un_set  = pop && empty;
    wa      = replace ? top : wp;
  end
  assign empty     = count == '0;
  assign full      = count == max_cnt;
  assign stack_out = empty ? '0 : mem[top];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp        <= do_push ? wp + PTR_W'(1) : do_pop ? wp - PTR_W'(1) : wp;
      count     <= (do_push && !full) ? count + (PTR_W+1)'(1) : do_pop ? count - (PTR_W+1)'(1) : count;
      overflow  <= (overflow && !clear_err) || ov_set;
      underflow <= (underflow && !clear_err) || un_set;
    end
  // Storage is never reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clk)
    if (reset && push) mem[wa] <= stack_in;
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: scoreboard bench; a queue-based stack model predicts every post-edge state.
module tb_return_addr_stack;
  localparam int DEPTH = 8;
  typedef struct {
    logic [11:0] so;
    logic [3:0]  cnt;
    logic        e, f, o, u;
    string       tag;
  } exp_t;

  logic clk = 0, reset = 0, push = 0, pop = 0, clear_err = 0;
  logic [11:0] stack_in = '0, stack_out;
  logic [3:0] count;
  logic empty, full, overflow, underflow;

  int checks = 0, fails = 0;
  exp_t sb[$];
  int stk[$];
  logic m_ov = 0, m_un = 0;

  return_addr_stack #(.DEPTH(8), .WIDTH(12), .PTR_W(3)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .stack_in(stack_in),
    .clear_err(clear_err), .stack_out(stack_out), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_state(string tag);
    exp_t x;
    x.so  = stk.size() > 0 ? 12'(stk[$]) : 12'h000;
    x.cnt = 4'(stk.size());
    x.e   = stk.size() == 0;
    x.f   = stk.size() == DEPTH;
    x.o   = m_ov;
    x.u   = m_un;
    x.tag = tag;
    return x;
  endfunction

  task automatic compare(exp_t x);
    checks++;
    if (stack_out !== x.so || count !== x.cnt || empty !== x.e || full !== x.f ||
        overflow !== x.o || underflow !== x.u) begin
      fails++;
      $display("FAIL %s: got so=%h cnt=%0d e=%b f=%b ov=%b un=%b, want so=%h cnt=%0d e=%b f=%b ov=%b un=%b",
               x.tag, stack_out, count, empty, full, overflow, underflow,
               x.so, x.cnt, x.e, x.f, x.o, x.u);
    end
  endtask

  // Monitor: every output sample after an edge is matched against the oldest prediction.
  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) compare(sb.pop_front());
  end

  task automatic step(input logic pu, input logic po, input logic [11:0] din, input logic clr, input string tag);
    logic ovs, uns;
    @(negedge clk);
    push = pu; pop = po; stack_in = din; clear_err = clr;
    #1;
    compare(model_state({tag, "_pre"}));
    ovs = 0; uns = 0;
    if (pu && po && stk.size() > 0) stk[$] = int'(din);
    else if (pu) begin
      if (po) uns = 1;
      if (stk.size() == DEPTH) begin
        void'(stk.pop_front());
        ovs = 1;
      end
      stk.push_back(int'(din));
    end else if (po) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else uns = 1;
    end
    m_ov = (clr ? 1'b0 : m_ov) | ovs;
    m_un = (clr ? 1'b0 : m_un) | uns;
    sb.push_back(model_state(tag));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    push = 0; pop = 0; clear_err = 0;
    #2 reset = 0;
    #1;
    stk.delete(); m_ov = 0; m_un = 0;
    compare(model_state({tag, "_async"}));
    sb.push_back(model_state({tag, "_held"}));
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    compare(model_state("reset_state"));
    // Mid-stream reset then underflow on release
    for (int i = 1; i <= 3; i++) step(1, 0, 12'(i * 16 + 5), 0, "pre_rst_push");
    do_reset("mid_reset");
    step(0, 1, 12'h0, 0, "pop_after_reset");
    step(0, 0, 12'h0, 1, "clear_un");
    // Basic push/pop
    step(1, 0, 12'h010, 0, "push10");
    step(1, 0, 12'h020, 0, "push20");
    step(1, 0, 12'h030, 0, "push30");
    step(0, 1, 12'h0, 0, "pop30");
    step(0, 1, 12'h0, 0, "pop20");
    step(0, 1, 12'h0, 0, "pop10");
    // Overflow wraps the oldest entry away
    for (int i = 1; i <= 9; i++) step(1, 0, 12'(i), 0, "ovf_push");
    for (int i = 0; i < 9; i++) step(0, 1, 12'h0, 0, "ovf_pop");
    step(0, 0, 12'h0, 1, "clear_both");
    // Tail-call replace
    step(1, 0, 12'h111, 0, "tc_push1");
    step(1, 0, 12'h0A5, 0, "tc_push2");
    step(1, 1, 12'h3C0, 0, "tc_replace");
    step(0, 1, 12'h0, 0, "tc_pop");
    step(0, 1, 12'h0, 0, "tc_pop2");
    // clear_err alone, then set-wins
    for (int i = 0; i < 9; i++) step(1, 0, 12'(12'h200 + i), 0, "fill");
    step(0, 0, 12'h0, 1, "clr_alone");
    step(1, 0, 12'h2FF, 1, "clr_vs_set");
    do_reset("reset2");
    // Push+pop on empty
    step(1, 1, 12'h7FF, 0, "pp_empty");
    step(0, 1, 12'h0, 0, "pp_empty_pop");
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 9);
      step(r < 4 || r == 8, r >= 4 && r != 9 && r >= 6, 12'($urandom), $urandom_range(0, 19) == 0, "rand");
      if ($urandom_range(0, 199) == 0) do_reset("rand_reset");
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, want completion");
    $fatal(1, "timeout");
  end
endmodule
